// File: rtl/alits01_sar_ctrl.sv
// Successive-approximation controller for the alits01 analog macro.
// Drives DAC trial codes and the track/hold strobe, and assembles the conversion result from the comparator.
module alits01_sar_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac_code,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int MAXC = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(WIDTH);

    localparam logic [CW-1:0]    SAMP_LAST  = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0]    SETL_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [IW-1:0]    BIT_TOP    = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    BIT_ONE    = IW'(1);
    localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [IW-1:0]    bit_dn;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            trial_q  <= trial_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        bit_dn = bit_q - BIT_ONE;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        trial_d  = trial_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                trial_d = '0;
                if (start) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SAMP_LAST) begin
                    state_d = ST_CONVERT;
                    cnt_d   = '0;
                    bit_d   = BIT_TOP;
                    trial_d = TRIAL_INIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_CONVERT: begin
                // cmp is only looked at on the last settle cycle of the current bit
                if (cnt_q == SETL_LAST) begin
                    cnt_d = '0;
                    if (!cmp) begin
                        trial_d[bit_q] = 1'b0;
                    end
                    if (bit_q != '0) begin
                        trial_d[bit_dn] = 1'b1;
                        bit_d           = bit_dn;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = trial_d;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Enable low wins over everything except reset and never loads result
        if (!ena) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            bit_d    = '0;
            trial_d  = '0;
            result_d = result_q;
        end
    end

    assign sample   = (state_q == ST_SAMPLE);
    assign busy     = (state_q == ST_SAMPLE) || (state_q == ST_CONVERT);
    assign done     = (state_q == ST_DONE);
    assign dac_code = (state_q == ST_CONVERT) ? trial_q : '0;
    assign result   = result_q;

endmodule

// File: tb/tb_alits01_sar_ctrl.sv
// Self-checking bench for alits01_sar_ctrl: vector table, corner sequences and randomized conversions
// checked against a binary-search reference model.
module tb_alits01_sar_ctrl;

    localparam int W    = 8;
    localparam int SC   = 2;
    localparam int ST   = 2;
    localparam int CONV = SC + W * ST;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         cmp;
    logic [W-1:0] dac_code;
    logic         sample;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] model_res;

    typedef struct {
        logic [7:0] vin;
        int         mode;
        logic [7:0] exp_res;
        string      name;
    } vec_t;

    vec_t tbl[7];

    alits01_sar_ctrl #(
        .WIDTH(W),
        .SAMPLE_CYC(SC),
        .SETTLE(ST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .cmp(cmp),
        .dac_code(dac_code),
        .sample(sample),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Comparator behaviour: 0 ideal, 1 forced low off the final settle cycle,
    // 2 stuck high, 3 stuck low, other = random off the final settle cycle.
    function automatic logic comp(input int mode, input logic [7:0] vin, input logic [7:0] dac, input bit fin);
        case (mode)
            0:       return vin >= dac;
            1:       return fin ? (vin >= dac) : 1'b0;
            2:       return 1'b1;
            3:       return 1'b0;
            default: return fin ? (vin >= dac) : 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_conv(input logic [7:0] vin, input int mode, input logic [7:0] exp_res, input string tag);
        logic [7:0]  trials[W];
        logic [7:0]  code;
        logic [7:0]  t;
        logic [10:0] ev;
        int          j;
        int          p;
        code = '0;
        for (int i = W - 1; i >= 0; i--) begin
            t = code | (8'(1) << i);
            trials[W-1-i] = t;
            if (comp(mode, vin, t, 1'b1)) code = t;
        end
        @(negedge clk);
        start = 1'b1;
        ena   = 1'b1;
        cmp   = comp(mode, vin, 8'h00, 1'b0);
        @(posedge clk);
        for (int k = 0; k <= CONV + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < SC) begin
                ev  = {1'b1, 1'b1, 1'b0, 8'h00};
                cmp = comp(mode, vin, 8'h00, 1'b0);
            end else if (k < CONV) begin
                j   = (k - SC) / ST;
                p   = (k - SC) % ST;
                ev  = {1'b0, 1'b1, 1'b0, trials[j]};
                cmp = comp(mode, vin, trials[j], p == ST - 1);
            end else if (k == CONV) begin
                ev = {1'b0, 1'b0, 1'b1, 8'h00};
            end else begin
                ev = '0;
            end
            check($sformatf("%s outs k=%0d", tag, k), {sample, busy, done, dac_code}, ev);
            if (k == 0) check($sformatf("%s held result", tag), result, model_res);
            if (k == CONV) begin
                check($sformatf("%s result", tag), result, exp_res);
                model_res = exp_res;
            end
        end
    endtask

    initial begin
        int          done_k[$];
        int          ndone;
        logic [7:0]  v;

        tbl[0] = '{8'hA5, 0, 8'hA5, "ideal_a5"};
        tbl[1] = '{8'h00, 2, 8'hFF, "stuck1"};
        tbl[2] = '{8'h00, 3, 8'h00, "stuck0"};
        tbl[3] = '{8'h80, 1, 8'h80, "glitch_80"};
        tbl[4] = '{8'h3C, 0, 8'h3C, "ideal_3c"};
        tbl[5] = '{8'h01, 0, 8'h01, "ideal_01"};
        tbl[6] = '{8'hFF, 0, 8'hFF, "ideal_ff"};

        rst_n = 1'b0;
        ena   = 1'b0;
        start = 1'b0;
        cmp   = 1'b0;
        model_res = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset c=%0d", c), {sample, busy, done, dac_code, result}, '0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_conv(tbl[i].vin, tbl[i].mode, tbl[i].exp_res, tbl[i].name);

        // start held high for 40 cycles: two conversions 20 edges apart
        @(negedge clk);
        start = 1'b1;
        ena   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cmp = (8'h3C >= dac_code);
            if (done) begin
                done_k.push_back(k);
                check("b2b result", result, 8'h3C);
            end
        end
        start = 1'b0;
        model_res = 8'h3C;
        check("b2b done count", done_k.size(), 2);
        if (done_k.size() == 2) begin
            check("b2b first done edge", done_k[0], CONV);
            check("b2b done spacing", done_k[1] - done_k[0], 20);
        end

        // abort via ena at edge 9
        run_conv(8'h5A, 0, 8'h5A, "pre_abort");
        @(negedge clk);
        start = 1'b1;
        ena   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            cmp   = (8'h5A >= dac_code);
            if (k == 8) ena = 1'b0;
        end
        @(negedge clk);
        check("abort outs", {sample, busy, done, dac_code, result}, {3'b000, 8'h00, 8'h5A});
        ena   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort stays idle", ndone, 0);
        check("abort result held", result, 8'h5A);

        // synchronous reset at edge 7 of a conversion
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            cmp   = 1'b1;
            if (k == 6) rst_n = 1'b0;
        end
        @(negedge clk);
        check("midreset outs", {sample, busy, done, dac_code, result}, '0);
        rst_n = 1'b1;
        model_res = '0;
        run_conv(8'h01, 0, 8'h01, "post_reset");

        for (int r = 0; r < 20; r++) begin
            v = 8'($urandom_range(0, 255));
            run_conv(v, 4, v, $sformatf("rand%0d", r));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alits01_sar_ctrl.md
Name: alits01_sar_ctrl

Overview:
- Digital successive-approximation controller for the alits01 analog macro: drives the DAC trial code and track/hold strobe onto the macro, reads back its comparator, and assembles a WIDTH-bit conversion result.
- Sits in the digital wrapper of the tile. The comparator arrives through a dedicated input, the DAC code leaves through the bidirectional pins, and the result goes to the dedicated outputs.

Parameters:
- WIDTH, 8: DAC and result resolution in bits (2..8).
- SAMPLE_CYC, 2: number of cycles the sample strobe stays high per conversion (>=1).
- SETTLE, 2: cycles each trial code is held before the comparator is sampled (>=1).

Ports:
- clk, input, 1: system clock, rising-edge.
- rst_n, input, 1: synchronous active-low reset.
- ena, input, 1: tile enable. Low aborts any conversion (synchronous).
- start, input, 1: conversion request, level-sampled in IDLE.
- cmp, input, 1: comparator from macro. 1 means Vin >= Vdac(dac_code). Already synchronised upstream.
- dac_code, output, WIDTH: trial code to the macro DAC.
- sample, output, 1: track/hold strobe to the macro.
- busy, output, 1: high in SAMPLE and CONVERT.
- done, output, 1: one-cycle pulse when result updates.
- result, output, WIDTH: last completed conversion, held until the next completion.

Behaviour:
- Reset and clocking: single clock domain (clk). Reset is synchronous and active-low (rst_n).
- Reset state: IDLE. dac_code=0, sample=0, busy=0, done=0, result=0, internal trial register=0, counters=0.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - Outputs: dac_code=0, sample=0.
  - If start=1 and ena=1 at an edge, go to SAMPLE at that edge.
- SAMPLE:
  - Outputs: sample=1, dac_code=0.
  - Lasts exactly SAMPLE_CYC cycles.
  - Then go to CONVERT with bit index i=WIDTH-1 and trial = 1<<(WIDTH-1).
- CONVERT:
  - Output: dac_code = trial.
  - Each bit i occupies exactly SETTLE cycles.
  - At the edge ending the SETTLE-th cycle, sample cmp. cmp=0 clears bit i of trial; cmp=1 keeps it.
  - If i>0, also set bit i-1 and decrement i.
  - If i=0, go to DONE and load result with the final trial.
- DONE:
  - Outputs: done=1 for exactly one cycle, busy=0, dac_code=0.
  - Next state is always IDLE. start is not sampled in DONE.
- Latency: if start is sampled at edge 0, done is high in the cycle following edge SAMPLE_CYC+WIDTH*SETTLE (edge 18 with defaults). result changes at that same edge.
- Back-to-back: start held high continuously gives a new SAMPLE entered at the edge after DONE (one IDLE cycle between conversions).
- start while busy or in DONE: ignored, with no queuing.
- ena=0 in any state:
  - Next state is IDLE; sample, dac_code and busy go to 0 at that edge.
  - No done pulse; result is unchanged.
- rst_n=0 mid-conversion: all reset values at that edge, including result=0.
- cmp is only observed on the final settle edge of each bit. Glitches on other cycles have no effect.
- Arithmetic:
  - Bit index counter is clog2(WIDTH) bits wide.
  - Settle and sample counters are wide enough for their parameter and do not wrap within a phase.

Test Plan:
1. Reset and ideal model:
   - Stimulus: hold rst_n=0 for 3 cycles, then model cmp=(0xA5 >= dac_code), pulse start.
   - Required: outputs all 0 during reset; dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, each held 2 cycles; done at edge 18; result=0xA5; busy high for 18 cycles.
2. Stuck comparator:
   - Stimulus: cmp=1 constant, then cmp=0 constant.
   - Required: result=0xFF, then result=0x00. Each conversion gives exactly one done pulse.
3. Start handling:
   - Stimulus: start held high for 40 cycles with model Vin=0x3C.
   - Required: two completed conversions, done pulses 20 edges apart, both result=0x3C. Extra start pulses mid-conversion do not change timing.
4. Abort via ena:
   - Stimulus: ena=0 at edge 9 of a conversion with previous result=0x5A.
   - Required: IDLE next cycle, sample=0, dac_code=0, busy=0, no done, result stays 0x5A.
5. Reset mid-conversion:
   - Stimulus: rst_n=0 for 1 cycle at edge 7, then a new start with Vin=0x01.
   - Required: all outputs 0 after the reset edge; subsequent conversion result=0x01.
6. Comparator glitch:
   - Stimulus: with Vin=0x80, force cmp=0 only on non-final settle cycles.
   - Required: result=0x80 unaffected.
